// File: rtl/nlg_pkg.sv
// Shared types and defaults for the two-level loop sequencer.
// Optional feature macro: NLG_AUTO_RESTART_EN (see nested_loop_gen.sv).
package nlg_pkg;

  localparam int NLG_W     = 8;
  localparam int NLG_CNT_W = 16;

  typedef enum logic [1:0] {
    NLG_IDLE = 2'd0,
    NLG_RUN  = 2'd1,
    NLG_DONE = 2'd2
  } nlg_state_e;

  localparam logic [1:0] ST_IDLE = 2'(NLG_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(NLG_RUN);
  localparam logic [1:0] ST_DONE = 2'(NLG_DONE);

endpackage

// File: rtl/nested_loop_gen_idx.sv
// W-bit loop index counter; wrap flags the increment that completes a lap.
// i_stay keeps the final index instead of returning to zero on that lap.
module nlg_idx_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_stay,
  input  logic [W-1:0] i_lim,
  output logic [W-1:0] o_value,
  output logic         o_wrap
);

  logic [W-1:0] r_value;
  logic [W-1:0] w_lim_m1;

  assign w_lim_m1 = i_lim - {{(W-1){1'b0}}, 1'b1};
  assign o_wrap   = i_inc & (r_value == w_lim_m1);
  assign o_value  = r_value;

  // index register: clear, step, or lap back to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= {W{1'b0}};
    end else if (i_clr) begin
      r_value <= {W{1'b0}};
    end else if (i_inc) begin
      if (o_wrap) begin
        if (i_stay) begin
          r_value <= r_value;
        end else begin
          r_value <= {W{1'b0}};
        end
      end else begin
        r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_value <= r_value;
    end
  end

endmodule

// File: rtl/nested_loop_gen.sv
// Two-level loop sequencer: emits (x,y) beats, y innermost, over valid/ready.
// Define NLG_AUTO_RESTART_EN to loop forever (DONE -> RUN) until abort.
module nested_loop_gen
  import nlg_pkg::*;
#(
  parameter int W     = NLG_W,
  parameter int CNT_W = NLG_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     x_lim,
  input  logic [W-1:0]     y_lim,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x,
  output logic [W-1:0]     y,
  output logic [CNT_W-1:0] act_cnt,
  output logic             busy,
  output logic             done
);

  logic [1:0]       r_state;
  logic [W-1:0]     r_xl;
  logic [W-1:0]     r_yl;
  logic [CNT_W-1:0] r_act;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_xfer;
  logic             w_start_ok;
  logic             w_in_zero;
  logic             w_lat_zero;
  logic             w_y_wrap;
  logic             w_x_wrap;
  logic             w_clr;
  logic             w_restart;
  logic [W-1:0]     w_x;
  logic [W-1:0]     w_y;

  assign w_xfer     = r_valid & out_ready;
  assign w_start_ok = start & ~abort;
  assign w_in_zero  = (x_lim == {W{1'b0}}) | (y_lim == {W{1'b0}});
  assign w_lat_zero = (r_xl == {W{1'b0}}) | (r_yl == {W{1'b0}});

  // index clear on an accepted start or on an automatic relaunch
  always_comb begin
    w_restart = 1'b0;
`ifdef NLG_AUTO_RESTART_EN
    if ((r_state == ST_DONE) && r_done && !abort && !w_lat_zero) begin
      w_restart = 1'b1;
    end else begin
      w_restart = 1'b0;
    end
`endif
    if ((r_state == ST_IDLE) && w_start_ok) begin
      w_clr = 1'b1;
    end else begin
      w_clr = w_restart;
    end
  end

  // The outer wrap is the last beat; both counters hold their final index then.
  nlg_idx_counter #(.W(W)) u_y_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_xfer),
    .i_stay (w_x_wrap),
    .i_lim  (r_yl),
    .o_value(w_y),
    .o_wrap (w_y_wrap)
  );

  nlg_idx_counter #(.W(W)) u_x_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_y_wrap),
    .i_stay (w_x_wrap),
    .i_lim  (r_xl),
    .o_value(w_x),
    .o_wrap (w_x_wrap)
  );

  // control FSM, latched limits and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_xl    <= {W{1'b0}};
      r_yl    <= {W{1'b0}};
      r_act   <= {CNT_W{1'b0}};
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_start_ok) begin
            r_xl  <= x_lim;
            r_yl  <= y_lim;
            r_act <= {CNT_W{1'b0}};
            if (w_in_zero) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_act <= r_act + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_x_wrap) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Zero-trip loops arrive here with r_done low and pulse one cycle later.
          if (abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (r_done) begin
            r_done <= 1'b0;
`ifdef NLG_AUTO_RESTART_EN
            if (w_lat_zero) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_act   <= {CNT_W{1'b0}};
            end
`else
            r_state <= ST_IDLE;
`endif
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign act_cnt   = r_act;
  assign x         = w_x;
  assign y         = w_y;

endmodule

// File: tb/tb_nested_loop_gen.sv
// Scoreboard bench for nested_loop_gen: expected beats come from a nested-loop
// reference model; a negedge monitor pops and compares on every transfer.
module tb_nested_loop_gen;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [W-1:0]     x_lim = '0;
  logic [W-1:0]     y_lim = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [CNT_W-1:0] act_cnt;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int first_valid_cyc = -1;
  int last_xfer_cyc = -1;
  int done_cyc = -1;
  int s_cyc = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  nested_loop_gen #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .x_lim    (x_lim),
    .y_lim    (y_lim),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x        (x),
    .y        (y),
    .act_cnt  (act_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ready pattern: 0 = always, 1 = toggling, other = random
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: every presented beat must match the head of the expected queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual x=%0d y=%0d required none", x, y);
        end else begin
          chk(out_ready ? "beat_xy" : "beat_hold_xy", {x, y}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
            last_xfer_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_model(input int xl, input int yl);
    exp_q.delete();
    for (int i = 0; i < xl; i++)
      for (int j = 0; j < yl; j++)
        exp_q.push_back({8'(i), 8'(j)});
    done_cnt = 0;
    xfer_cnt = 0;
    first_valid_cyc = -1;
    last_xfer_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic issue_start(input int xl, input int yl);
    start = 1'b1;
    x_lim = 8'(xl);
    y_lim = 8'(yl);
    s_cyc = cyc;
    tick();
    start = 1'b0;
    x_lim = 8'($urandom);
    y_lim = 8'($urandom);
  endtask

  task automatic run_loop(input int xl, input int yl, input int mode);
    int n;
    int total;
    total = xl * yl;
    ready_mode = mode;
    load_model(xl, yl);
    issue_start(xl, yl);
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done xl=%0d yl=%0d", xl, yl);
    end
    repeat (3) tick();
    chk("done_pulses", done_cnt, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("xfer_count", xfer_cnt, total);
    chk("act_cnt", act_cnt, total);
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
    if (total == 0) begin
      chk("zero_no_valid", first_valid_cyc, -1);
      chk("zero_done_lat", done_cyc - s_cyc, 2);
    end else begin
      chk("first_valid_lat", first_valid_cyc - s_cyc, 1);
      chk("done_after_last", done_cyc - last_xfer_cyc, 1);
      if (mode == 0) chk("done_lat", done_cyc - s_cyc, total + 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_act", act_cnt, 0);
    rst_n = 1'b1;
    tick();

    run_loop(10, 10, 0);
    run_loop(3, 2, 1);
    run_loop(0, 5, 0);
    run_loop(4, 0, 2);

    // abort coincident with the 37th transfer
    ready_mode = 0;
    load_model(10, 10);
    issue_start(10, 10);
    repeat (36) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_act", act_cnt, 37);
    chk("abort_xfers", xfer_cnt, 37);
    repeat (4) tick();
    chk("abort_no_done", done_cnt, 0);
    run_loop(2, 3, 0);

    // start while running is ignored, then reset mid-run
    ready_mode = 0;
    load_model(10, 10);
    issue_start(10, 10);
    repeat (20) tick();
    start = 1'b1;
    x_lim = 8'd2;
    y_lim = 8'd2;
    tick();
    start = 1'b0;
    chk("ign_start_busy", busy, 1);
    chk("ign_start_act", act_cnt, 21);
    chk("ign_start_xy", {x, y}, {8'd2, 8'd1});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_xy", {x, y}, 0);
    chk("mid_rst_act", act_cnt, 0);
    tick();

    for (int k = 0; k < 8; k++) begin
      run_loop(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
